// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps every input vector of a small combinational
// block in ascending order, holds each one for DWELL cycles, captures the
// block outputs at the end of each dwell and compares them to a golden table.
module truth_table_sequencer #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned DWELL  = 20,
  parameter logic [(2**N_IN)*N_OUT-1:0] GOLDEN = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  output logic [N_IN-1:0]             vec_out,
  input  logic [N_OUT-1:0]            dut_in,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [N_IN:0]               err_count,
  output logic [N_IN-1:0]             first_fail,
  output logic [(2**N_IN)*N_OUT-1:0]  table_out
);

  localparam int unsigned NUM_VEC = 2 ** N_IN;
  localparam int unsigned ERR_W   = N_IN + 1;
  localparam int unsigned CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dwell_cnt;
  logic [N_OUT-1:0] golden_c;
  logic             dwell_end_c;
  logic             last_vec_c;
  logic             mismatch_c;

  // Golden entry for the vector currently applied (vec_out doubles as the index)
  always_comb begin
    golden_c = '0;
    for (int unsigned k = 0; k < NUM_VEC; k++) begin
      if (vec_out == N_IN'(k)) golden_c = GOLDEN[k*N_OUT +: N_OUT];
    end
  end

  assign dwell_end_c = (dwell_cnt == CNT_W'(DWELL - 1));
  assign last_vec_c  = (vec_out == N_IN'(NUM_VEC - 1));
  assign mismatch_c  = (dut_in != golden_c);

  // Pass is only meaningful once the sweep has completed
  assign pass = done && (err_count == '0);

  // Sweep controller: abort has priority, start only honoured outside SETTLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vec_out    <= '0;
      dwell_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      table_out  <= '0;
    end else if (abort) begin
      // Partial results are kept for post-mortem inspection
      state     <= S_IDLE;
      vec_out   <= '0;
      dwell_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_SETTLE;
            vec_out    <= '0;
            dwell_cnt  <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            table_out  <= '0;
          end
        end
        S_SETTLE: begin
          if (dwell_end_c) begin
            for (int unsigned k = 0; k < NUM_VEC; k++) begin
              if (vec_out == N_IN'(k)) table_out[k*N_OUT +: N_OUT] <= dut_in;
            end
            if (mismatch_c) begin
              err_count <= err_count + ERR_W'(1);
              if (err_count == '0) first_fail <= vec_out;
            end
            if (last_vec_c) begin
              // Terminal vector ends the sweep; vec_out holds it
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec_out   <= vec_out + N_IN'(1);
              dwell_cnt <= '0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: three instances (matching golden, corrupted
// golden, DWELL=1) share clock and controls; results are checked against a
// table-level model of the sweep.
module tb_truth_table_sequencer;

  localparam int NV = 16;

  // Reference block under test: f = a ^ b, g = c & d, vector bits {a,b,c,d}
  function automatic logic [1:0] ref_fn(input int k);
    logic [3:0] v;
    v = 4'(k);
    return {v[3] ^ v[2], v[1] & v[0]};
  endfunction

  function automatic logic [31:0] make_golden(input bit corrupt);
    logic [31:0] g;
    g = '0;
    for (int k = 0; k < NV; k++) begin
      g[k*2 +: 2] = ref_fn(k) ^ ((corrupt && (k == 5 || k == 12)) ? 2'b01 : 2'b00);
    end
    return g;
  endfunction

  localparam logic [31:0] GOLD_OK  = make_golden(1'b0);
  localparam logic [31:0] GOLD_BAD = make_golden(1'b1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  logic [3:0]  vec_a, vec_b, vec_c;
  logic [1:0]  in_a, in_b, in_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [4:0]  err_a, err_b, err_c;
  logic [3:0]  ff_a, ff_b, ff_c;
  logic [31:0] tab_a, tab_b, tab_c;

  logic [1:0] rand_tt [NV];
  bit         rand_mode = 1'b0;

  assign in_a = rand_mode ? rand_tt[vec_a] : ref_fn(int'(vec_a));
  assign in_b = ref_fn(int'(vec_b));
  assign in_c = ref_fn(int'(vec_c));

  truth_table_sequencer #(.N_IN(4), .N_OUT(2), .DWELL(4), .GOLDEN(GOLD_OK)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_out(vec_a),
    .dut_in(in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail(ff_a), .table_out(tab_a));

  truth_table_sequencer #(.N_IN(4), .N_OUT(2), .DWELL(4), .GOLDEN(GOLD_BAD)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_out(vec_b),
    .dut_in(in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail(ff_b), .table_out(tab_b));

  truth_table_sequencer #(.N_IN(4), .N_OUT(2), .DWELL(1), .GOLDEN(GOLD_OK)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_out(vec_c),
    .dut_in(in_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .first_fail(ff_c), .table_out(tab_c));

  int n_checks = 0;
  int n_errors = 0;
  int dedge [3];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Model of the block seen by each instance
  function automatic logic [1:0] blk(input int inst, input int k);
    if (inst == 0 && rand_mode) return rand_tt[k];
    return ref_fn(k);
  endfunction

  function automatic logic [1:0] gold(input int inst, input int k);
    logic [31:0] g;
    g = (inst == 1) ? GOLD_BAD : GOLD_OK;
    return g[k*2 +: 2];
  endfunction

  // Vectors sampled before an abort at edge e (0 = no abort)
  function automatic int nsamp(input int dwell, input int e);
    int s;
    if (e == 0) return NV;
    s = (e - 1) / dwell;
    return (s > NV) ? NV : s;
  endfunction

  task automatic grab(input int i, output logic [31:0] tab, output logic [31:0] err,
                      output logic [31:0] ff, output logic dn, output logic ps, output logic bs);
    case (i)
      0:       begin tab = tab_a; err = 32'(err_a); ff = 32'(ff_a); dn = done_a; ps = pass_a; bs = busy_a; end
      1:       begin tab = tab_b; err = 32'(err_b); ff = 32'(ff_b); dn = done_b; ps = pass_b; bs = busy_b; end
      default: begin tab = tab_c; err = 32'(err_c); ff = 32'(ff_c); dn = done_c; ps = pass_c; bs = busy_c; end
    endcase
  endtask

  // Compare one instance against the model after n vectors were captured
  task automatic check_inst(input int inst, input int n, input bit exp_done, input string tag);
    logic [31:0] etab, tab, err, ff;
    logic dn, ps, bs;
    int eerr, eff;
    etab = '0; eerr = 0; eff = 0;
    for (int k = 0; k < n; k++) begin
      etab[k*2 +: 2] = blk(inst, k);
      if (blk(inst, k) != gold(inst, k)) begin
        if (eerr == 0) eff = k;
        eerr++;
      end
    end
    grab(inst, tab, err, ff, dn, ps, bs);
    check($sformatf("%s_table", tag), tab, etab);
    check($sformatf("%s_err", tag), err, 32'(eerr));
    if (eerr != 0) check($sformatf("%s_first_fail", tag), ff, 32'(eff));
    check($sformatf("%s_done", tag), 32'(dn), 32'(exp_done));
    check($sformatf("%s_pass", tag), 32'(ps), 32'(exp_done && eerr == 0));
    check($sformatf("%s_busy", tag), 32'(bs), 32'd0);
  endtask

  // One sweep: start edge is edge 0; start_at/abort_at name the edge sampling them
  task automatic sweep(input int abort_at, input int start_at, input int stop_at, input string tag);
    int bad;
    int ev;
    bit eb;
    bad = 0;
    for (int i = 0; i < 3; i++) dedge[i] = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("%s_start_busy", tag), 32'(busy_a), 32'd1);
    check($sformatf("%s_start_cleared", tag), {err_b, 27'd0} | tab_b, 32'd0);
    for (int n = 1; n <= stop_at; n++) begin
      start = (n == start_at);
      abort = (n == abort_at);
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (abort_at != 0 && n >= abort_at) begin
        ev = 0; eb = 1'b0;
      end else begin
        ev = (n < 64) ? n / 4 : 15;
        eb = (n < 64);
      end
      if (vec_a !== 4'(ev) || busy_a !== eb) bad++;
      if (done_a === 1'b1 && dedge[0] < 0) dedge[0] = n;
      if (done_b === 1'b1 && dedge[1] < 0) dedge[1] = n;
      if (done_c === 1'b1 && dedge[2] < 0) dedge[2] = n;
      if (n == abort_at) break;
    end
    check($sformatf("%s_vec_busy_seq", tag), 32'(bad), 32'd0);
  endtask

  typedef struct {
    string name;
    int    abort_at;
    int    start_at;
    int    exp_done_a;
    int    exp_done_c;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int ab, st;
    for (int k = 0; k < NV; k++) rand_tt[k] = 2'b00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec", 32'(vec_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_ff", 32'(ff_a), 32'd0);
    check("rst_table", tab_b, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start", 32'(busy_a), 32'd0);

    // Table of full/aborted sweeps: matching, start ignored while busy, abort at vec 7
    vecs[0] = '{name: "match",   abort_at: 0,  start_at: 0,  exp_done_a: 64, exp_done_c: 16};
    vecs[1] = '{name: "restart", abort_at: 0,  start_at: 13, exp_done_a: 64, exp_done_c: 16};
    vecs[2] = '{name: "abort7",  abort_at: 30, start_at: 0,  exp_done_a: -1, exp_done_c: 16};
    for (int i = 0; i < 3; i++) begin
      sweep(vecs[i].abort_at, vecs[i].start_at, 70, vecs[i].name);
      check($sformatf("%s_done_edge_a", vecs[i].name), 32'(dedge[0]), 32'(vecs[i].exp_done_a));
      check($sformatf("%s_done_edge_b", vecs[i].name), 32'(dedge[1]), 32'(vecs[i].exp_done_a));
      check($sformatf("%s_done_edge_c", vecs[i].name), 32'(dedge[2]), 32'(vecs[i].exp_done_c));
      check_inst(0, nsamp(4, vecs[i].abort_at), vecs[i].abort_at == 0, {vecs[i].name, "_a"});
      check_inst(1, nsamp(4, vecs[i].abort_at), vecs[i].abort_at == 0, {vecs[i].name, "_b"});
      check_inst(2, nsamp(1, vecs[i].abort_at), vecs[i].abort_at == 0, {vecs[i].name, "_c"});
      if (i == 0) begin
        check("fault_err", 32'(err_b), 32'd2);
        check("fault_first_fail", 32'(ff_b), 32'd5);
        check("fault_entry5", 32'(tab_b[11:10]), 32'd2);
        check("fault_entry12", 32'(tab_b[25:24]), 32'd0);
        check("match_table_golden", tab_a, GOLD_OK);
      end
    end
    check("abort_vec_c", 32'(vec_c), 32'd0);
    check("abort_partial_err_b", 32'(err_b), 32'd1);

    // Reset asserted at vec 9: outputs clear before the next edge
    sweep(0, 0, 37, "rst_mid");
    check("rst_mid_vec_before", 32'(vec_a), 32'd9);
    rst_n = 1'b0;
    #1;
    check("rst_mid_vec", 32'(vec_a), 32'd0);
    check("rst_mid_busy", 32'(busy_a), 32'd0);
    check("rst_mid_err_b", 32'(err_b), 32'd0);
    check("rst_mid_table_b", tab_b, 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_stay_idle", {28'd0, vec_a} | 32'(busy_a), 32'd0);

    // DWELL=1 rerun
    sweep(0, 0, 70, "dwell1");
    check("dwell1_done_edge", 32'(dedge[2]), 32'd16);
    check_inst(2, NV, 1'b1, "dwell1_c");

    // Randomized truth tables, abort points and ignored start pulses
    rand_mode = 1'b1;
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < NV; k++) rand_tt[k] = 2'($urandom_range(0, 3));
      ab = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 66));
      st = int'($urandom_range(0, 15));
      if (ab != 0 && st > ab) st = ab;
      sweep(ab, st, 70, $sformatf("rnd%0d", it));
      if (ab == 0) check($sformatf("rnd%0d_done_edge", it), 32'(dedge[0]), 32'd64);
      check_inst(0, nsamp(4, ab), ab == 0, $sformatf("rnd%0d_a", it));
      check_inst(1, nsamp(4, ab), ab == 0, $sformatf("rnd%0d_b", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
